adc_sample_fetch: RTL and testbench

ADC_SAMPLE_FETCH -- requirements
Module: adc_sample_fetch

---
 rtl/audio_pkg.sv | 15 +
 rtl/rd_lat_pipe.sv | 36 +++
 rtl/adc_sample_fetch.sv | 120 ++++++++++++
 tb/tb_adc_sample_fetch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio datapath types and defaults
package audio_pkg;

  localparam int SAMPLE_W_DEF = 24;
  localparam int RD_LAT_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ_L = 3'd1,
    ST_REQ_R = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/rd_lat_pipe.sv
// rtl/rd_lat_pipe.sv - parameterised strobe delay line
module rd_lat_pipe #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3
) (
  input  logic             alg_clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge alg_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/adc_sample_fetch.sv
// rtl/adc_sample_fetch.sv - fetches one left/right ADC pair per frame tick
module adc_sample_fetch
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int RD_LAT   = RD_LAT_DEF
) (
  input  logic                       alg_clk,
  input  logic                       resetn,
  input  logic                       sample_tick,
  output logic                       send_next_sample,
  input  logic [31:0]                adc_word,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] out_left,
  output logic signed [SAMPLE_W-1:0] out_right,
  output logic                       overrun,
  output logic [7:0]                 overrun_cnt
);

  fetch_state_e state_q, state_d;

  logic                sns_q, sns_d;
  logic                is_right_d;
  logic                out_valid_q, out_valid_d;
  logic [SAMPLE_W-1:0] left_stage_q, left_stage_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic [SAMPLE_W-1:0] right_q, right_d;
  logic                overrun_q, overrun_d;
  logic [7:0]          ovr_cnt_q, ovr_cnt_d;

  logic [1:0]          tap;
  logic                cap_l, cap_r;
  logic [SAMPLE_W-1:0] sample;
  logic                unused_lsbs;

  // Strobe pipe is fed with the next-cycle strobe, so its last stage lines up
  // with the cycle in which adc_word carries the requested word.
  rd_lat_pipe #(
    .WIDTH (2),
    .DEPTH (RD_LAT + 1)
  ) u_rd_lat_pipe (
    .alg_clk (alg_clk),
    .resetn  (resetn),
    .din     ({is_right_d, sns_d}),
    .dout    (tap)
  );

  assign cap_l       = tap[0] & ~tap[1];
  assign cap_r       = tap[0] & tap[1];
  assign sample      = adc_word[31:32-SAMPLE_W];
  assign unused_lsbs = ^adc_word[31-SAMPLE_W:0];

  always_ff @(posedge alg_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sample_tick) state_d = ST_REQ_L;
      ST_REQ_L: state_d = ST_REQ_R;
      ST_REQ_R: state_d = ST_WAIT;
      ST_WAIT:  if (cap_r) state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sns_d        = (state_d == ST_REQ_L) || (state_d == ST_REQ_R);
    is_right_d   = (state_d == ST_REQ_R);
    out_valid_d  = (state_d == ST_HOLD);
    left_stage_d = cap_l ? sample : left_stage_q;
    left_d       = left_q;
    right_d      = right_q;
    if ((state_q == ST_WAIT) && cap_r) begin
      left_d  = left_stage_q;
      right_d = sample;
    end
    // Any tick outside IDLE is dropped, including one coinciding with acceptance.
    overrun_d = sample_tick && (state_q != ST_IDLE);
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_d && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge alg_clk or negedge resetn) begin
    if (!resetn) begin
      sns_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      left_stage_q <= '0;
      left_q       <= '0;
      right_q      <= '0;
      overrun_q    <= 1'b0;
      ovr_cnt_q    <= 8'd0;
    end else begin
      sns_q        <= sns_d;
      out_valid_q  <= out_valid_d;
      left_stage_q <= left_stage_d;
      left_q       <= left_d;
      right_q      <= right_d;
      overrun_q    <= overrun_d;
      ovr_cnt_q    <= ovr_cnt_d;
    end
  end

  assign send_next_sample = sns_q;
  assign out_valid        = out_valid_q;
  assign out_left         = left_q;
  assign out_right        = right_q;
  assign overrun          = overrun_q;
  assign overrun_cnt      = ovr_cnt_q;

endmodule

// File: tb/tb_adc_sample_fetch.sv
// tb/tb_adc_sample_fetch.sv - self-checking bench for adc_sample_fetch
module tb_adc_sample_fetch;

  localparam int SW = 24;

  logic          alg_clk = 1'b0;
  logic          resetn = 1'b1;
  logic          sample_tick = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   adc_word = 32'h0;
  logic          send_next_sample;
  logic          out_valid;
  logic [SW-1:0] out_left;
  logic [SW-1:0] out_right;
  logic          overrun;
  logic [7:0]    overrun_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  adc_sample_fetch dut (
    .alg_clk          (alg_clk),
    .resetn           (resetn),
    .sample_tick      (sample_tick),
    .send_next_sample (send_next_sample),
    .adc_word         (adc_word),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_left         (out_left),
    .out_right        (out_right),
    .overrun          (overrun),
    .overrun_cnt      (overrun_cnt)
  );

  always #5 alg_clk = ~alg_clk;

  // ADC input stage: a read in cycle k presents its word in cycle k+2, garbage otherwise.
  logic [31:0] fifo[$];
  logic s1 = 1'b0, s2 = 1'b0;
  always @(posedge alg_clk) begin
    #1;
    if (s2 && fifo.size() > 0) adc_word = fifo.pop_front();
    else adc_word = $urandom;
    s2 = s1;
    s1 = send_next_sample;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge alg_clk);
    #1;
  endtask

  task automatic do_reset();
    sample_tick = 1'b0;
    out_ready   = 1'b0;
    resetn      = 1'b0;
    step();
    step();
    fifo.delete();
    resetn = 1'b1;
  endtask

  // Starts a fetch in cycle 0 and returns in cycle 5 with out_valid expected high.
  task automatic fetch_to_valid(input string nm, input logic [31:0] wl, input logic [31:0] wr,
                                input logic [SW-1:0] el, input logic [SW-1:0] er);
    fifo.push_back(wl);
    fifo.push_back(wr);
    sample_tick = 1'b1;
    out_ready   = 1'b0;
    step();
    sample_tick = 1'b0;
    check({nm, " sns c1"}, send_next_sample, 1);
    step();
    check({nm, " sns c2"}, send_next_sample, 1);
    step();
    check({nm, " sns c3"}, send_next_sample, 0);
    step();
    check({nm, " valid c4"}, out_valid, 0);
    step();
    check({nm, " valid c5"}, out_valid, 1);
    check({nm, " left"}, out_left, el);
    check({nm, " right"}, out_right, er);
  endtask

  typedef struct {
    string         nm;
    logic [31:0]   wl;
    logic [31:0]   wr;
    logic [SW-1:0] el;
    logic [SW-1:0] er;
  } vec_t;

  vec_t vt[4];

  initial begin
    int            cnt;
    bit            stable;
    bit            seen;
    logic [SW-1:0] kl, kr;
    bit            m_busy, m_valid, m_ovr;
    int            m_age, m_cnt;
    logic [SW-1:0] m_left, m_right, p_left, p_right;
    logic [31:0]   wl, wr;
    bit            tick, rdy, n_ovr;

    vt[0] = '{"nominal", 32'h12345600, 32'hFEDCBA00, 24'h123456, 24'hFEDCBA};
    vt[1] = '{"sign",    32'h80000000, 32'h7FFFFF00, 24'h800000, 24'h7FFFFF};
    vt[2] = '{"lsbdrop", 32'h000001FF, 32'hFFFFFFFF, 24'h000001, 24'hFFFFFF};
    vt[3] = '{"extreme", 32'h7FFFFFAB, 32'h800000CD, 24'h7FFFFF, 24'h800000};

    sample_tick = 1'b0;
    resetn = 1'b0;
    step();
    step();
    check("rst sns", send_next_sample, 0);
    check("rst valid", out_valid, 0);
    check("rst left", out_left, 0);
    check("rst right", out_right, 0);
    check("rst overrun", overrun, 0);
    check("rst cnt", overrun_cnt, 0);
    resetn = 1'b1;

    // Tick in the very first cycle after release.
    for (int i = 0; i < 4; i++) begin
      fetch_to_valid(vt[i].nm, vt[i].wl, vt[i].wr, vt[i].el, vt[i].er);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({vt[i].nm, " valid drop"}, out_valid, 0);
      check({vt[i].nm, " left kept"}, out_left, vt[i].el);
      step();
    end

    // Backpressure with a tick inside the hold window.
    do_reset();
    fetch_to_valid("bp", 32'hA1B2C3D4, 32'h0F1E2D3C, 24'hA1B2C3, 24'h0F1E2D);
    stable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      sample_tick = (i == 2);
      step();
      sample_tick = 1'b0;
      if (out_left !== 24'hA1B2C3 || out_right !== 24'h0F1E2D || out_valid !== 1'b1) stable = 1'b0;
      cnt += int'(send_next_sample);
      if (i == 2) begin
        check("bp overrun pulse", overrun, 1);
        check("bp overrun cnt", overrun_cnt, 1);
      end
      if (i == 3) check("bp overrun low", overrun, 0);
    end
    check("bp stable", stable, 1);
    check("bp no reads", cnt, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp accepted", out_valid, 0);

    // Tick collision during REQ_L.
    do_reset();
    fifo.push_back(32'h11223300);
    fifo.push_back(32'h44556600);
    sample_tick = 1'b1;
    step();
    cnt = int'(send_next_sample);
    step();
    sample_tick = 1'b0;
    cnt += int'(send_next_sample);
    check("coll overrun", overrun, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      cnt += int'(send_next_sample);
    end
    check("coll valid", out_valid, 1);
    check("coll left", out_left, 24'h112233);
    check("coll right", out_right, 24'h445566);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      cnt += int'(send_next_sample);
    end
    out_ready = 1'b0;
    check("coll reads", cnt, 2);
    check("coll cnt", overrun_cnt, 1);

    // Reset while in WAIT; outputs still hold the collision pair and count 1.
    fifo.push_back(32'hCAFEBA00);
    fifo.push_back(32'hDEADBE00);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    resetn = 1'b0;
    #1;
    check("mid rst sns", send_next_sample, 0);
    check("mid rst valid", out_valid, 0);
    check("mid rst left", out_left, 0);
    check("mid rst right", out_right, 0);
    check("mid rst cnt", overrun_cnt, 0);
    step();
    resetn = 1'b1;
    seen = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b0) seen = 1'b1;
      cnt += int'(send_next_sample);
    end
    check("mid rst no valid", seen, 0);
    check("mid rst no reads", cnt, 0);
    fifo.delete();

    // Saturation of the overrun counter.
    do_reset();
    fetch_to_valid("sat", 32'h01020300, 32'h04050600, 24'h010203, 24'h040506);
    sample_tick = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 99) check("sat cnt 100", overrun_cnt, 100);
    end
    check("sat cnt 255", overrun_cnt, 255);
    for (int i = 0; i < 5; i++) step();
    sample_tick = 1'b0;
    step();
    check("sat cnt stays", overrun_cnt, 255);
    check("sat still valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();

    // Randomized run against a transaction-level reference model.
    do_reset();
    m_busy = 0; m_valid = 0; m_ovr = 0; m_age = 0; m_cnt = 0;
    m_left = '0; m_right = '0; p_left = '0; p_right = '0;
    for (int c = 0; c < 2000; c++) begin
      tick = ($urandom_range(0, 7) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      if (tick && !m_busy) begin
        wl = $urandom;
        wr = $urandom;
        fifo.push_back(wl);
        fifo.push_back(wr);
        p_left  = wl[31:8];
        p_right = wr[31:8];
      end
      sample_tick = tick;
      out_ready   = rdy;
      check("rnd sns", send_next_sample, (m_busy && !m_valid && (m_age == 1 || m_age == 2)));
      check("rnd valid", out_valid, m_valid);
      check("rnd left", out_left, m_left);
      check("rnd right", out_right, m_right);
      check("rnd overrun", overrun, m_ovr);
      check("rnd cnt", overrun_cnt, m_cnt);
      n_ovr = tick && m_busy;
      if (n_ovr && m_cnt < 255) m_cnt++;
      if (m_busy) begin
        if (m_valid) begin
          if (rdy) begin
            m_busy  = 0;
            m_valid = 0;
          end
        end else begin
          m_age++;
          if (m_age == 5) begin
            m_valid = 1;
            m_left  = p_left;
            m_right = p_right;
          end
        end
      end else if (tick) begin
        m_busy = 1;
        m_age  = 1;
      end
      m_ovr = n_ovr;
      step();
    end
    sample_tick = 1'b0;
    out_ready   = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
